pri_arbiter: RTL
================

# pri_arbiter

Eight-way request arbiter that shares one downstream resource between eight requesters. It picks a winner with the team's highest-index-wins priority encoding, either fixed or round-robin, and holds the grant until the owner releases it or a hold timeout expires. It sits in front of any shared datapath unit and issues a registered one-hot grant plus the encoded owner index.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one grant may be held; legal range 2..256.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset.
- en  in  1  arbitration enable; when low, no new grant is issued.
- mode  in  1  0 = fixed priority, 1 = round-robin; sampled only when arbitrating.
- req  in  8  request vector, level-sensitive, bit i = requester i.
- done  in  1  owner signals completion; meaningful only while busy.
- gnt  out  8  one-hot grant, registered.
- gnt_id  out  3  index of the current owner; 0 when not busy.
- busy  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse after a forced release.

## Operation
- The FSM has two states: IDLE and GRANT.
- **IDLE:** if en=1 and req≠0, arbitrate, then on the clock edge:
  - load gnt and gnt_id with the winner and set busy=1,
  - clear the hold counter, set last=winner, go to GRANT.
- **Fixed mode (mode=0):** the highest set index of req wins.
- **Round-robin mode (mode=1):** form masked = req & ((1<<last)-1).
  - If masked≠0, the highest set index of masked wins.
  - Otherwise the highest set index of req wins (wrap-around).
- **GRANT:** the grant is released on the first cycle where any of these holds:
  - done=1,
  - req[gnt_id]=0,
  - hold counter = MAX_HOLD-1 (forced release).
- **On release** (next edge): gnt=0, gnt_id=0, busy=0, go to IDLE. Otherwise increment the hold counter.
- **timeout** is set on the release edge only when the release is forced and neither done nor the req drop caused it.
- **en=0 during GRANT:** no effect. The grant persists until a release condition.
- **mode changes during GRANT:** ignored until the next arbitration.
- **last pointer:**
  - 3 bits, reset 0, updated only on a new grant.
  - At reset the round-robin order therefore starts at 7, matching fixed priority.
- **Hold counter:** width $clog2(MAX_HOLD); it never wraps, because forced release occurs at MAX_HOLD-1.

## Timing
- **Reset values:** gnt=0, gnt_id=0, busy=0, timeout=0, last=0, hold counter=0, state IDLE.
- **rst asserted mid-grant:** all outputs read reset values in the cycle after the edge. No timeout pulse is generated.
- **Grant latency:** req sampled on edge k produces gnt/gnt_id/busy visible after edge k, i.e. one cycle.
- **Maximum hold:** gnt stays high for at most MAX_HOLD cycles.
- **Release latency:** done on cycle c clears gnt after the edge ending c.
- **Inter-grant gap:** at least one cycle with gnt=0 between any two grants, including re-grant to the same requester. That cycle is the IDLE arbitration cycle.
- **timeout pulse:** high for exactly that first gnt=0 cycle, and never coincident with gnt≠0.
- **Simultaneous done and forced release:** counts as done; timeout=0.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Structure
- **Shared package pri_arb_pkg:**
  - state enum (IDLE, GRANT),
  - N_REQ=8 and ID_W=3 constants.
- **Sub-module prio_enc8:** combinational.
  - Inputs: d[7:0].
  - Outputs: y[2:0] = highest set index, valid = |d.
- **Instances:** two prio_enc8, one on req and one on the masked vector. The FSM selects between them by mode and masked-valid.
- **Size target:** about 150–200 lines including the encoder.

## Test plan
- **Fixed priority:** after reset, mode=0, en=1, req=8'b0010_0100 → next cycle gnt=8'b0010_0000, gnt_id=5, busy=1. Then done=1 for one cycle → gnt=0 and busy=0 one cycle later, then re-grant to 5.
- **Round-robin sweep:** mode=1, req=8'hFF held, done pulsed on the first GRANT cycle of every grant → gnt_id sequence 7,6,5,4,3,2,1,0,7, with exactly one gnt=0 cycle between grants.
- **Forced release:** MAX_HOLD=16, mode=0, req=8'h08 held, done=0 → gnt=8'h08 for exactly 16 cycles, then gnt=0 with timeout=1 for one cycle, then gnt=8'h08 again.
- **Requester drop:** req drops mid-grant → gnt=0 after the next edge, timeout=0. Separately, done=1 on cycle 15 of a 16-cycle hold → timeout=0.
- **Enable:** en=0 with req=8'h10 → gnt stays 0 indefinitely. en dropped to 0 during a grant → the grant persists until done.
- **Reset mid-grant:** rst=1 while gnt=8'h04, mode=1 → next cycle all outputs 0. Then req=8'h81 → grant 7, confirming last was reset to 0.

Source files
------------

// File: rtl/pri_arb_pkg.sv
// Shared constants and FSM state type for the eight-way priority arbiter.
package pri_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder: y is the highest set index of d.
module prio_enc8
  import pri_arb_pkg::*;
(
  input  logic [N_REQ-1:0] d,
  output logic [ID_W-1:0]  y,
  output logic             valid
);

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps the block latch-free.
    y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (d[i]) y = ID_W'(i);
    end
  end

  assign valid = |d;

endmodule

// File: rtl/pri_arbiter.sv
// Eight-way arbiter, fixed or round-robin highest-index-wins, with a hold
// timeout. All outputs are registered.
module pri_arbiter
  import pri_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [ID_W-1:0]  last;
  logic [CNT_W-1:0] hold_cnt;

  logic [N_REQ-1:0] masked;
  logic [ID_W-1:0]  req_y, mask_y, win_id;
  logic             req_v, mask_v;
  logic             owner_req, forced;

  // Round-robin only considers requesters strictly below the last winner.
  assign masked = req & ((N_REQ'(1) << last) - N_REQ'(1));

  prio_enc8 u_enc_req  (.d(req),    .y(req_y),  .valid(req_v));
  prio_enc8 u_enc_mask (.d(masked), .y(mask_y), .valid(mask_v));

  assign win_id    = (mode && mask_v) ? mask_y : req_y;
  assign owner_req = req[gnt_id];
  assign forced    = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      last     <= '0;
      hold_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // sees the pre-edge values regardless of statement order.
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && req_v) begin
            state    <= GRANT;
            gnt      <= N_REQ'(1) << win_id;
            gnt_id   <= win_id;
            busy     <= 1'b1;
            last     <= win_id;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (done || !owner_req || forced) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            // A voluntary release wins over a coincident timeout.
            timeout  <= !done && owner_req;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
